// File: rtl/state_log_pkg.sv
// state_log_pkg: state encodings, frame length and snapshot word order shared by logger, serializer and BMC decoder
package state_log_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;
  localparam int W_CUR = 3;
  localparam int W_P2 = 2;
  localparam int W_P1 = 1;
  localparam int W_P0 = 0;
  function automatic int frame_len(input int bits);
    return 4 * bits;
  endfunction
endpackage

// File: rtl/state_log_bit_timer.sv
// state_log_bit_timer: bit-period divider producing the period boundary tick and the serial clock
module state_log_bit_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic en,
  input  logic sclk_en,
  output logic per_tick,
  output logic half,
  output logic oSClk
);
  localparam int PER = 2 * CLK_DIV;
  localparam int DW = $clog2(PER) > 0 ? $clog2(PER) : 1;
  logic [DW-1:0] div_cnt;
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) div_cnt <= '0;
    else div_cnt <= (!en || per_tick) ? '0 : div_cnt + 1'b1;
  // per_tick marks the last cycle of a period; the next period starts at its closing edge
  always_comb begin
    per_tick = en && div_cnt == DW'(PER - 1);
    half = div_cnt >= DW'(CLK_DIV);
    oSClk = sclk_en && half;
  end
endmodule

// File: rtl/state_log_serializer.sv
// state_log_serializer: snapshots the four logged state words and shifts them out on SClk/SLoad/SData
module state_log_serializer
  import state_log_pkg::*;
#(
  parameter int bits = 8,
  parameter int CLK_DIV = 2
) (
  input  logic            iClk,
  input  logic            iRst_n,
  input  logic [bits-1:0] iCurState,
  input  logic [bits-1:0] iPrevState2,
  input  logic [bits-1:0] iPrevState1,
  input  logic [bits-1:0] iPrevState0,
  input  logic            iStart,
  input  logic            iAutoEn,
  output logic            oBusy,
  output logic            oDone,
  output logic            oSClk,
  output logic            oSLoad,
  output logic            oSData
);
  localparam int N = frame_len(bits);
  localparam int BW = $clog2(N) > 0 ? $clog2(N) : 1;
  state_t state, state_nx;
  logic [N-1:0] live, snap, last_sent;
  logic [BW-1:0] bit_cnt;
  logic pending, launch, per_tick, last_bit;
  state_log_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .iClk(iClk),
    .iRst_n(iRst_n),
    .en(state != ST_IDLE),
    .sclk_en(state == ST_SHIFT),
    .per_tick(per_tick),
    .half(),
    .oSClk(oSClk)
  );
  always_comb begin
    live = '0;
    live[W_CUR*bits +: bits] = iCurState;
    live[W_P2*bits +: bits] = iPrevState2;
    live[W_P1*bits +: bits] = iPrevState1;
    live[W_P0*bits +: bits] = iPrevState0;
  end
  always_comb begin
    launch = state == ST_IDLE && (iStart || (iAutoEn && pending));
    last_bit = bit_cnt == BW'(N - 1);
    state_nx = launch ? ST_LOAD :
               state == ST_LOAD && per_tick ? ST_SHIFT :
               state == ST_SHIFT && per_tick && last_bit ? ST_IDLE : state;
    oBusy = state != ST_IDLE;
    oSLoad = state == ST_LOAD;
    oSData = state == ST_SHIFT && snap[N-1];
  end
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      state <= ST_IDLE;
      snap <= '0;
      last_sent <= '0;
      pending <= 1'b0;
      bit_cnt <= '0;
      oDone <= 1'b0;
    end else begin
      state <= state_nx;
      oDone <= state == ST_SHIFT && per_tick && last_bit;
      pending <= !launch && (pending || (iAutoEn && live != last_sent));
      if (launch) begin
        snap <= live;
        last_sent <= live;
      end else if (state == ST_SHIFT && per_tick) snap <= snap << 1;
      bit_cnt <= state != ST_SHIFT ? '0 : per_tick && !last_bit ? bit_cnt + 1'b1 : bit_cnt;
    end
endmodule

// File: tb/tb_state_log_serializer.sv
// tb_state_log_serializer: randomized scoreboard bench with a frame-level reference model
module tb_state_log_serializer;
  localparam int BITS = 8;
  localparam int CD = 2;
  localparam int N = 4 * BITS;
  localparam int BUSY = (N + 1) * 2 * CD;
  logic iClk = 0, iRst_n = 0, iStart = 0, iAutoEn = 0;
  logic [BITS-1:0] iCurState = 0, iPrevState2 = 0, iPrevState1 = 0, iPrevState0 = 0;
  logic oBusy, oDone, oSClk, oSLoad, oSData;
  int tests = 0, fails = 0, dones = 0;
  logic [N-1:0] exp_q[$];
  int m_cnt = 0;
  logic m_pend = 0, m_done = 0;
  logic [N-1:0] m_last = '0;

  state_log_serializer #(.bits(BITS), .CLK_DIV(CD)) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iCurState(iCurState), .iPrevState2(iPrevState2),
    .iPrevState1(iPrevState1), .iPrevState0(iPrevState0),
    .iStart(iStart), .iAutoEn(iAutoEn),
    .oBusy(oBusy), .oDone(oDone), .oSClk(oSClk), .oSLoad(oSLoad), .oSData(oSData)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] live();
    return {iCurState, iPrevState2, iPrevState1, iPrevState0};
  endfunction

  // Reference: a frame is a fixed-length busy window; expected frame data queued at launch
  initial forever begin
    @(posedge iClk or negedge iRst_n);
    if (!iRst_n) begin
      m_cnt = 0; m_pend = 0; m_done = 0; m_last = '0;
      exp_q.delete();
    end else begin
      m_done = (m_cnt == 1);
      if (m_cnt > 0) begin
        m_cnt--;
        m_pend = m_pend | (iAutoEn && live() != m_last);
      end else if (iStart || (iAutoEn && m_pend)) begin
        m_cnt = BUSY; m_last = live(); m_pend = 0;
        exp_q.push_back(live());
      end else m_pend = m_pend | (iAutoEn && live() != m_last);
    end
  end

  // Monitor: decode the serial link and compare against the scoreboard
  initial begin
    int nb, ld;
    logic ps;
    logic [N-1:0] sh;
    nb = 0; ld = 0; ps = 0; sh = '0;
    forever begin
      @(negedge iClk);
      if (!iRst_n) begin
        nb = 0; ld = 0; ps = 0;
      end else begin
        chk("busy", 32'(oBusy), 32'(m_cnt > 0));
        chk("done", 32'(oDone), 32'(m_done));
        if (oDone) dones++;
        if (!oBusy) chk("idle_lines", 32'({oSClk, oSLoad, oSData}), 0);
        if (oSLoad) begin
          ld++; nb = 0;
          chk("load_lines", 32'({oSClk, oSData}), 0);
        end else if (ld > 0) begin
          chk("load_len", 32'(ld), 2 * CD);
          ld = 0;
        end
        if (oSClk && !ps) begin
          sh = {sh[N-2:0], oSData};
          nb++;
          if (nb == N) begin
            nb = 0;
            if (exp_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL frame_unexpected actual=%h required=none", sh);
            end else chk("frame", sh, exp_q.pop_front());
          end
        end
        ps = oSClk;
      end
    end
  end

  task automatic set_in(input logic [31:0] v);
    {iCurState, iPrevState2, iPrevState1, iPrevState0} = v;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge iClk);
  endtask

  task automatic pulse_start();
    iStart = 1;
    @(negedge iClk);
    iStart = 0;
  endtask

  task automatic wait_idle();
    int s, k;
    s = 0; k = 0;
    while (s < 4 && k < 2000) begin
      @(negedge iClk);
      k++;
      s = oBusy ? 0 : s + 1;
    end
    if (s < 4) begin
      tests++; fails++;
      $display("FAIL idle_timeout actual=busy required=idle within %0d cycles", k);
    end
  endtask

  task automatic wait_busy();
    int k;
    k = 0;
    while (!oBusy && k < 50) begin
      @(negedge iClk);
      k++;
    end
    chk("auto_launch", 32'(oBusy), 1);
  endtask

  initial begin
    int n, d0;
    cyc(3);
    chk("reset_outs", 32'({oBusy, oDone, oSClk, oSLoad, oSData}), 0);
    iRst_n = 1;
    cyc(2);
    // basic frame, ignored second start, inputs changed mid-shift
    set_in(32'hA53C0F81);
    d0 = dones;
    iStart = 1;
    n = 0;
    do begin
      @(negedge iClk);
      n++;
      if (n == 1 || n == 51) iStart = 0;
      if (n == 50) iStart = 1;
      if (n == 60) set_in($urandom);
    end while (!oDone && n < 300);
    chk("latency", 32'(n), BUSY + 1);
    wait_idle();
    chk("busy_ignore_dones", 32'(dones - d0), 1);
    // auto mode
    set_in(0);
    pulse_start();
    wait_idle();
    iAutoEn = 1;
    cyc(10);
    d0 = dones;
    iCurState = 8'h11;
    wait_busy();
    cyc(40);
    iCurState = 8'h22;
    wait_idle();
    cyc(300);
    chk("auto_dones", 32'(dones - d0), 2);
    // start coincident with a snapshot change
    d0 = dones;
    iStart = 1;
    iCurState = 8'h33;
    @(negedge iClk);
    iStart = 0;
    wait_idle();
    cyc(50);
    chk("simul_dones", 32'(dones - d0), 1);
    iAutoEn = 0;
    // asynchronous reset mid-frame
    set_in($urandom);
    pulse_start();
    cyc(69);
    #2 iRst_n = 0;
    #1 chk("async_reset", 32'({oBusy, oDone, oSClk, oSLoad, oSData}), 0);
    d0 = dones;
    cyc(3);
    iRst_n = 1;
    cyc(2);
    set_in($urandom);
    pulse_start();
    wait_idle();
    chk("post_reset_dones", 32'(dones - d0), 1);
    // random traffic
    for (int i = 0; i < 2500; i++) begin
      @(negedge iClk);
      iStart = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 0) set_in($urandom);
        else iPrevState1 = 8'($urandom);
      end
      if ($urandom_range(0, 199) == 0) iAutoEn = ~iAutoEn;
    end
    iStart = 0;
    iAutoEn = 0;
    wait_idle();
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
